// File: rtl/switch_allocator_pkg.sv
// Shared widths, flit type IDs and per-output FSM encoding for switch_allocator.
package switch_allocator_pkg;

  localparam int IN_N        = 5;
  localparam int OUT_N       = 5;
  localparam int IN_N_W      = 3;
  localparam int OUT_N_W     = 3;
  localparam int FLIT_DATA_W = 8;
  localparam int FLIT_ID_W   = 2;
  localparam int FLIT_W      = FLIT_ID_W + FLIT_DATA_W;

  // Flit type occupies the top FLIT_ID_W bits of each flit.
  localparam int FLIT_ID_HI = FLIT_W - 1;
  localparam int FLIT_ID_LO = FLIT_DATA_W;

  localparam logic [FLIT_ID_W-1:0] HEADER_ID = 2'b10;
  localparam logic [FLIT_ID_W-1:0] TAIL_ID   = 2'b11;

  typedef enum logic [1:0] {
    FREE   = 2'b01,
    LOCKED = 2'b10
  } out_state_e;

  function automatic logic [FLIT_ID_W-1:0] flit_id(input logic [FLIT_W-1:0] f);
    return f[FLIT_ID_HI:FLIT_ID_LO];
  endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Signal bundle between the VC stage, the switch allocator and the output buffers.
interface switch_allocator_if;
  import switch_allocator_pkg::*;

  logic [IN_N*OUT_N_W-1:0] route_res_i;
  logic [IN_N-1:0]         route_res_vld_i;
  logic [IN_N*FLIT_W-1:0]  data_i;
  logic [IN_N-1:0]         data_vld_i;
  logic [OUT_N-1:0]        out_rdy_i;
  logic [IN_N-1:0]         chan_alloc_o;
  logic [IN_N-1:0]         chan_rdy_o;
  logic [OUT_N*FLIT_W-1:0] out_data_o;
  logic [OUT_N-1:0]        out_vld_o;

  modport master (
    output route_res_i, route_res_vld_i, data_i, data_vld_i, out_rdy_i,
    input  chan_alloc_o, chan_rdy_o, out_data_o, out_vld_o
  );

  modport slave (
    input  route_res_i, route_res_vld_i, data_i, data_vld_i, out_rdy_i,
    output chan_alloc_o, chan_rdy_o, out_data_o, out_vld_o
  );

endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr_i wins.
module rr_arbiter #(
  parameter int N     = 5,
  parameter int PTR_W = 3
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic             gnt_vld_o
);

  int w_idx;

  always_comb begin
    gnt_o     = '0;
    gnt_vld_o = 1'b0;
    w_idx     = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(ptr_i) + k) % N;
      if (!gnt_vld_o && req_i[w_idx]) begin
        gnt_o[w_idx] = 1'b1;
        gnt_vld_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Per-output round-robin switch allocation with header-to-tail locking and crossbar.
// Defining SW_ALLOC_WATCHDOG_EN adds per-output stall watchdogs and the wd_err_o port.
module switch_allocator
  import switch_allocator_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  switch_allocator_if.slave bus
`ifdef SW_ALLOC_WATCHDOG_EN
  ,
  output logic [OUT_N-1:0]  wd_err_o
`endif
);

  logic [OUT_N_W-1:0] w_route     [IN_N];
  logic [FLIT_W-1:0]  w_flit      [IN_N];
  logic [IN_N-1:0]    w_req       [OUT_N];
  logic [IN_N-1:0]    w_gnt       [OUT_N];
  logic [OUT_N-1:0]   w_gnt_vld;
  out_state_e         r_state     [OUT_N];
  out_state_e         w_state_nxt [OUT_N];
  logic [IN_N_W-1:0]  r_owner     [OUT_N];
  logic [IN_N_W-1:0]  w_owner_nxt [OUT_N];
  logic [IN_N_W-1:0]  r_ptr       [OUT_N];
  logic [IN_N_W-1:0]  w_ptr_nxt   [OUT_N];
  logic [IN_N-1:0]    r_chan_alloc;
  logic [IN_N-1:0]    w_chan_alloc_nxt;
  logic [IN_N-1:0]    w_chan_rdy;
  logic [FLIT_W-1:0]  w_out_flit  [OUT_N];
  logic [OUT_N*FLIT_W-1:0] w_out_data;
  logic [OUT_N-1:0]   w_out_vld;
  logic [OUT_N-1:0]   w_accept;
  logic [OUT_N-1:0]   w_release;
  logic [OUT_N-1:0]   w_wd_fire;

  function automatic logic [IN_N_W-1:0] gnt_to_idx(input logic [IN_N-1:0] g);
    logic [IN_N_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < IN_N; i++)
      if (g[i]) idx = IN_N_W'(i);
    return idx;
  endfunction

  always_comb begin
    for (int i = 0; i < IN_N; i++) begin
      w_route[i] = bus.route_res_i[i*OUT_N_W +: OUT_N_W];
      w_flit[i]  = bus.data_i[i*FLIT_W +: FLIT_W];
    end
  end

  // Allocated VCs are masked so a VC can never hold more than one output.
  always_comb begin
    for (int o = 0; o < OUT_N; o++)
      for (int i = 0; i < IN_N; i++)
        w_req[o][i] = bus.route_res_vld_i[i] && (w_route[i] == OUT_N_W'(o)) && !r_chan_alloc[i];
  end

  always_comb begin
    for (int i = 0; i < IN_N; i++)
      w_chan_rdy[i] = (int'(w_route[i]) < OUT_N) ? bus.out_rdy_i[w_route[i]] : 1'b0;
  end

  for (genvar o = 0; o < OUT_N; o++) begin : g_arb
    rr_arbiter #(.N(IN_N), .PTR_W(IN_N_W)) u_arb (
      .req_i     (w_req[o]),
      .ptr_i     (r_ptr[o]),
      .gnt_o     (w_gnt[o]),
      .gnt_vld_o (w_gnt_vld[o])
    );
  end

  always_comb begin
    w_out_data = '0;
    for (int o = 0; o < OUT_N; o++) begin
      w_out_flit[o] = '0;
      w_out_vld[o]  = 1'b0;
      if (r_state[o] == LOCKED) begin
        w_out_flit[o] = w_flit[r_owner[o]];
        w_out_vld[o]  = bus.data_vld_i[r_owner[o]];
      end
      w_accept[o]  = w_out_vld[o] && bus.out_rdy_i[o];
      w_release[o] = w_accept[o] && (flit_id(w_out_flit[o]) == TAIL_ID);
      w_out_data[o*FLIT_W +: FLIT_W] = w_out_flit[o];
    end
  end

  // Arbitration only happens from FREE, so a release cycle is always followed by a bubble.
  always_comb begin
    w_chan_alloc_nxt = '0;
    for (int o = 0; o < OUT_N; o++) begin
      w_state_nxt[o] = r_state[o];
      w_owner_nxt[o] = r_owner[o];
      w_ptr_nxt[o]   = r_ptr[o];
      case (r_state[o])
        FREE: begin
          if (w_gnt_vld[o]) begin
            w_state_nxt[o] = LOCKED;
            w_owner_nxt[o] = gnt_to_idx(w_gnt[o]);
            w_ptr_nxt[o]   = (w_owner_nxt[o] == IN_N_W'(IN_N-1)) ? '0
                                                                : w_owner_nxt[o] + IN_N_W'(1);
          end
        end
        LOCKED: begin
          if (w_release[o] || w_wd_fire[o]) w_state_nxt[o] = FREE;
        end
        default: w_state_nxt[o] = FREE;
      endcase
      if (w_state_nxt[o] == LOCKED) w_chan_alloc_nxt[w_owner_nxt[o]] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int o = 0; o < OUT_N; o++) begin
        r_state[o] <= FREE;
        r_owner[o] <= '0;
        r_ptr[o]   <= '0;
      end
      r_chan_alloc <= '0;
    end else begin
      for (int o = 0; o < OUT_N; o++) begin
        r_state[o] <= w_state_nxt[o];
        r_owner[o] <= w_owner_nxt[o];
        r_ptr[o]   <= w_ptr_nxt[o];
      end
      r_chan_alloc <= w_chan_alloc_nxt;
    end
  end

`ifdef SW_ALLOC_WATCHDOG_EN
  logic [7:0]       r_wd_cnt [OUT_N];
  logic [OUT_N-1:0] r_wd_err;

  always_comb begin
    for (int o = 0; o < OUT_N; o++)
      w_wd_fire[o] = (r_state[o] == LOCKED) && (r_wd_cnt[o] == 8'hFF);
  end

  // Counter idles at zero while FREE, so a fresh lock always starts from zero.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int o = 0; o < OUT_N; o++) r_wd_cnt[o] <= '0;
      r_wd_err <= '0;
    end else begin
      for (int o = 0; o < OUT_N; o++) begin
        if (r_state[o] != LOCKED || w_accept[o]) r_wd_cnt[o] <= '0;
        else                                     r_wd_cnt[o] <= r_wd_cnt[o] + 8'd1;
      end
      r_wd_err <= w_wd_fire;
    end
  end

  assign wd_err_o = r_wd_err;
`else
  assign w_wd_fire = '0;
`endif

  assign bus.chan_alloc_o = r_chan_alloc;
  assign bus.chan_rdy_o   = w_chan_rdy;
  assign bus.out_data_o   = w_out_data;
  assign bus.out_vld_o    = w_out_vld;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed, table-driven bench for switch_allocator plus hand sequences for
// backpressure, mid-packet reset and (when built in) the watchdog.
module tb_switch_allocator;
  import switch_allocator_pkg::*;

  localparam int RW = IN_N * OUT_N_W;
  localparam int DW = IN_N * FLIT_W;
  localparam int OW = OUT_N * FLIT_W;
  localparam logic [1:0] H = HEADER_ID;
  localparam logic [1:0] T = TAIL_ID;
  localparam logic [1:0] B = 2'b00;

  typedef struct {
    string           name;
    logic            rstN;
    logic [RW-1:0]   route;
    logic [IN_N-1:0] routeVld;
    logic [DW-1:0]   data;
    logic [IN_N-1:0] dataVld;
    logic [OUT_N-1:0] outRdy;
    logic [IN_N-1:0] expAlloc;
    logic [IN_N-1:0] expRdy;
    logic [OUT_N-1:0] expVld;
    logic [OW-1:0]   expData;
  } vec_t;

  logic clk;
  logic rstN;
  int   nVectors = 0;
  int   nMiscompares = 0;
  vec_t vecs[$];

  switch_allocator_if busIf();

`ifdef SW_ALLOC_WATCHDOG_EN
  logic [OUT_N-1:0] wdErr;
`endif

  switch_allocator dut (
    .clk_i  (clk),
    .rst_ni (rstN),
    .bus    (busIf.slave)
`ifdef SW_ALLOC_WATCHDOG_EN
    ,
    .wd_err_o (wdErr)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [RW-1:0] rt(input int vc, input int o);
    logic [RW-1:0] r;
    r = '0;
    r[vc*OUT_N_W +: OUT_N_W] = OUT_N_W'(o);
    return r;
  endfunction

  function automatic logic [DW-1:0] fl(input int slot, input logic [1:0] id, input logic [7:0] b);
    logic [DW-1:0] r;
    r = '0;
    r[slot*FLIT_W +: FLIT_W] = {id, b};
    return r;
  endfunction

  function automatic vec_t mkVec(input string name, input logic rs, input logic [RW-1:0] route,
                                 input logic [IN_N-1:0] rv, input logic [DW-1:0] data,
                                 input logic [IN_N-1:0] dv, input logic [OUT_N-1:0] ordy,
                                 input logic [IN_N-1:0] eAlloc, input logic [IN_N-1:0] eRdy,
                                 input logic [OUT_N-1:0] eVld, input logic [OW-1:0] eData);
    vec_t v;
    v.name = name; v.rstN = rs; v.route = route; v.routeVld = rv; v.data = data;
    v.dataVld = dv; v.outRdy = ordy; v.expAlloc = eAlloc; v.expRdy = eRdy;
    v.expVld = eVld; v.expData = eData;
    return v;
  endfunction

  task automatic checkOutput(input vec_t v);
    nVectors++;
    if (busIf.chan_alloc_o !== v.expAlloc) begin
      nMiscompares++;
      $display("[TB] FAIL %s chan_alloc_o: got %b, want %b", v.name, busIf.chan_alloc_o, v.expAlloc);
    end
    if (busIf.chan_rdy_o !== v.expRdy) begin
      nMiscompares++;
      $display("[TB] FAIL %s chan_rdy_o: got %b, want %b", v.name, busIf.chan_rdy_o, v.expRdy);
    end
    if (busIf.out_vld_o !== v.expVld) begin
      nMiscompares++;
      $display("[TB] FAIL %s out_vld_o: got %b, want %b", v.name, busIf.out_vld_o, v.expVld);
    end
    if (busIf.out_data_o !== v.expData) begin
      nMiscompares++;
      $display("[TB] FAIL %s out_data_o: got %h, want %h", v.name, busIf.out_data_o, v.expData);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked 1 ns later, before the next rising edge.
  task automatic applyStimulus(input vec_t v);
    rstN                  = v.rstN;
    busIf.route_res_i     = v.route;
    busIf.route_res_vld_i = v.routeVld;
    busIf.data_i          = v.data;
    busIf.data_vld_i      = v.dataVld;
    busIf.out_rdy_i       = v.outRdy;
    #1;
    checkOutput(v);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rstN = 1'b0;
    busIf.route_res_i     = '0;
    busIf.route_res_vld_i = '0;
    busIf.data_i          = '0;
    busIf.data_vld_i      = '0;
    busIf.out_rdy_i       = 5'h1F;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);

    // name, rstN, route, routeVld, data, dataVld, outRdy | alloc, rdy, vld, data
    vecs.push_back(mkVec("reset",        0, '0, 5'b00000, '0, 5'b00000, 5'h1F, 5'b00000, 5'h1F, 5'b00000, '0));
    vecs.push_back(mkVec("pkt_req",      1, rt(0,2), 5'b00001, fl(0,H,8'hA1), 5'b00001, 5'h1F, 5'b00000, 5'h1F, 5'b00000, '0));
    vecs.push_back(mkVec("pkt_hdr",      1, rt(0,2), 5'b00000, fl(0,H,8'hA1), 5'b00001, 5'h1F, 5'b00001, 5'h1F, 5'b00100, fl(2,H,8'hA1)));
    vecs.push_back(mkVec("pkt_body1",    1, rt(0,2), 5'b00000, fl(0,B,8'hA2), 5'b00001, 5'h1F, 5'b00001, 5'h1F, 5'b00100, fl(2,B,8'hA2)));
    vecs.push_back(mkVec("pkt_body2",    1, rt(0,2), 5'b00000, fl(0,B,8'hA3), 5'b00001, 5'h1F, 5'b00001, 5'h1F, 5'b00100, fl(2,B,8'hA3)));
    vecs.push_back(mkVec("pkt_tail",     1, rt(0,2), 5'b00000, fl(0,T,8'hA4), 5'b00001, 5'h1F, 5'b00001, 5'h1F, 5'b00100, fl(2,T,8'hA4)));
    vecs.push_back(mkVec("pkt_free",     1, rt(0,2), 5'b00000, '0, 5'b00000, 5'h1F, 5'b00000, 5'h1F, 5'b00000, '0));
    vecs.push_back(mkVec("cont_req",     1, '0, 5'b01010, fl(1,H,8'hC1) | fl(3,H,8'hD1), 5'b01010, 5'h1F, 5'b00000, 5'h1F, 5'b00000, '0));
    vecs.push_back(mkVec("cont_vc1_hdr", 1, '0, 5'b01000, fl(1,H,8'hC1) | fl(3,H,8'hD1), 5'b01010, 5'h1F, 5'b00010, 5'h1F, 5'b00001, fl(0,H,8'hC1)));
    vecs.push_back(mkVec("cont_vc1_tail",1, '0, 5'b01000, fl(1,T,8'hC2) | fl(3,H,8'hD1), 5'b01010, 5'h1F, 5'b00010, 5'h1F, 5'b00001, fl(0,T,8'hC2)));
    vecs.push_back(mkVec("cont_bubble",  1, '0, 5'b01000, fl(3,H,8'hD1), 5'b01000, 5'h1F, 5'b00000, 5'h1F, 5'b00000, '0));
    vecs.push_back(mkVec("cont_vc3_hdr", 1, '0, 5'b00000, fl(3,H,8'hD1), 5'b01000, 5'h1F, 5'b01000, 5'h1F, 5'b00001, fl(0,H,8'hD1)));
    vecs.push_back(mkVec("cont_vc3_tail",1, '0, 5'b00000, fl(3,T,8'hD2), 5'b01000, 5'h1F, 5'b01000, 5'h1F, 5'b00001, fl(0,T,8'hD2)));
    vecs.push_back(mkVec("cont_free",    1, '0, 5'b00000, '0, 5'b00000, 5'h1F, 5'b00000, 5'h1F, 5'b00000, '0));
    vecs.push_back(mkVec("ptr4_req",     1, '0, 5'b10001, '0, 5'b00000, 5'h1F, 5'b00000, 5'h1F, 5'b00000, '0));
    vecs.push_back(mkVec("ptr4_vc4_win", 1, '0, 5'b00001, fl(4,T,8'hE1), 5'b10000, 5'h1F, 5'b10000, 5'h1F, 5'b00001, fl(0,T,8'hE1)));
    vecs.push_back(mkVec("wrap_rereq",   1, '0, 5'b10001, '0, 5'b00000, 5'h1F, 5'b00000, 5'h1F, 5'b00000, '0));
    vecs.push_back(mkVec("wrap_vc0_win", 1, '0, 5'b10000, fl(0,T,8'hF1), 5'b00001, 5'h1F, 5'b00001, 5'h1F, 5'b00001, fl(0,T,8'hF1)));
    vecs.push_back(mkVec("wrap_bubble",  1, '0, 5'b10000, '0, 5'b00000, 5'h1F, 5'b00000, 5'h1F, 5'b00000, '0));
    vecs.push_back(mkVec("wrap_vc4_next",1, '0, 5'b00000, fl(4,T,8'hE2), 5'b10000, 5'h1F, 5'b10000, 5'h1F, 5'b00001, fl(0,T,8'hE2)));
    vecs.push_back(mkVec("par_req",      1, rt(0,3) | rt(2,1), 5'b00101, fl(0,H,8'h61) | fl(2,H,8'h71), 5'b00101, 5'h1F, 5'b00000, 5'h1F, 5'b00000, '0));
    vecs.push_back(mkVec("par_hdr",      1, rt(0,3) | rt(2,1), 5'b00000, fl(0,H,8'h61) | fl(2,H,8'h71), 5'b00101, 5'h1F, 5'b00101, 5'h1F, 5'b01010, fl(3,H,8'h61) | fl(1,H,8'h71)));
    vecs.push_back(mkVec("par_split",    1, rt(0,3) | rt(2,1), 5'b00000, fl(0,T,8'h62) | fl(2,H,8'h71), 5'b00001, 5'h1F, 5'b00101, 5'h1F, 5'b01000, fl(3,T,8'h62) | fl(1,H,8'h71)));
    vecs.push_back(mkVec("par_tail1",    1, rt(0,3) | rt(2,1), 5'b00000, fl(2,T,8'h72), 5'b00100, 5'h1F, 5'b00100, 5'h1F, 5'b00010, fl(1,T,8'h72)));
    vecs.push_back(mkVec("par_free",     1, rt(0,3) | rt(2,1), 5'b00000, '0, 5'b00000, 5'h1F, 5'b00000, 5'h1F, 5'b00000, '0));
    vecs.push_back(mkVec("bad_route",    1, rt(1,5), 5'b00010, '0, 5'b00000, 5'h1F, 5'b00000, 5'h1D, 5'b00000, '0));
    vecs.push_back(mkVec("bad_route_rdy",1, rt(1,5) | rt(2,4), 5'b00010, '0, 5'b00000, 5'b01111, 5'b00000, 5'b11001, 5'b00000, '0));

    foreach (vecs[k]) applyStimulus(vecs[k]);

    // Backpressure: tail on out 1 is held until out_rdy_i[1] returns.
    applyStimulus(mkVec("bp_req",   1, rt(3,1), 5'b01000, fl(3,H,8'h91), 5'b01000, 5'h1F,    5'b00000, 5'h1F, 5'b00000, '0));
    applyStimulus(mkVec("bp_hdr",   1, rt(3,1), 5'b00000, fl(3,H,8'h91), 5'b01000, 5'h1F,    5'b01000, 5'h1F, 5'b00010, fl(1,H,8'h91)));
    applyStimulus(mkVec("bp_stall1",1, rt(3,1), 5'b00000, fl(3,T,8'h92), 5'b01000, 5'b11101, 5'b01000, 5'h17, 5'b00010, fl(1,T,8'h92)));
    applyStimulus(mkVec("bp_stall2",1, rt(3,1), 5'b00000, fl(3,T,8'h92), 5'b01000, 5'b11101, 5'b01000, 5'h17, 5'b00010, fl(1,T,8'h92)));
    applyStimulus(mkVec("bp_accept",1, rt(3,1), 5'b00000, fl(3,T,8'h92), 5'b01000, 5'h1F,    5'b01000, 5'h1F, 5'b00010, fl(1,T,8'h92)));
    applyStimulus(mkVec("bp_free",  1, rt(3,1), 5'b00000, '0, 5'b00000, 5'h1F,               5'b00000, 5'h1F, 5'b00000, '0));

    // Reset while out 2 is mid-packet drops the lock on the next edge.
    applyStimulus(mkVec("rst_req",   1, rt(2,2), 5'b00100, fl(2,H,8'hB1), 5'b00100, 5'h1F, 5'b00000, 5'h1F, 5'b00000, '0));
    applyStimulus(mkVec("rst_hdr",   1, rt(2,2), 5'b00000, fl(2,H,8'hB1), 5'b00100, 5'h1F, 5'b00100, 5'h1F, 5'b00100, fl(2,H,8'hB1)));
    applyStimulus(mkVec("rst_assert",0, rt(2,2), 5'b00000, fl(2,B,8'hB2), 5'b00100, 5'h1F, 5'b00100, 5'h1F, 5'b00100, fl(2,B,8'hB2)));
    applyStimulus(mkVec("rst_after", 1, rt(2,2), 5'b00000, fl(2,B,8'hB3), 5'b00100, 5'h1F, 5'b00000, 5'h1F, 5'b00000, '0));
    applyStimulus(mkVec("rst_stays", 1, rt(2,2), 5'b00000, fl(2,B,8'hB3), 5'b00100, 5'h1F, 5'b00000, 5'h1F, 5'b00000, '0));

`ifdef SW_ALLOC_WATCHDOG_EN
    begin
      int edges;
      applyStimulus(mkVec("wd_req", 1, rt(2,2), 5'b00100, '0, 5'b00000, 5'h1F, 5'b00000, 5'h1F, 5'b00000, '0));
      edges = 0;
      while (wdErr === 5'b00000 && edges < 400) begin
        @(posedge clk);
        @(negedge clk);
        edges++;
        #1;
      end
      nVectors++;
      if (edges != 256) begin
        nMiscompares++;
        $display("[TB] FAIL wd_latency: pulse after %0d edges, want 256", edges);
      end
      nVectors++;
      if (wdErr !== 5'b00100 || busIf.chan_alloc_o !== 5'b00000) begin
        nMiscompares++;
        $display("[TB] FAIL wd_release: wd_err %b alloc %b, want 00100 and 00000", wdErr, busIf.chan_alloc_o);
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      nVectors++;
      if (wdErr !== 5'b00000) begin
        nMiscompares++;
        $display("[TB] FAIL wd_pulse_width: wd_err %b, want 00000", wdErr);
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
